// File: rtl/apb_share_arbiter.sv
// Round-robin sharing of one APB target port between NM masters. Ownership is
// held while the owner keeps psel high; a watchdog aborts stalled transfers.
module apb_share_arbiter #(
    parameter int unsigned NM      = 2,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned TW      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NM-1:0]     m_psel,
    input  logic [NM-1:0]     m_penable,
    input  logic [NM-1:0]     m_pwrite,
    input  logic [32*NM-1:0]  m_paddr,
    input  logic [32*NM-1:0]  m_pwdata,
    input  logic [4*NM-1:0]   m_pstrb,
    output logic [NM-1:0]     m_pready,
    output logic [2*NM-1:0]   m_presp,
    output logic [31:0]       m_prdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [31:0]       paddr,
    output logic [31:0]       pwdata,
    output logic [3:0]        pstrb,
    input  logic              pready,
    input  logic [1:0]        presp,
    input  logic [31:0]       prdata,
    output logic [NM-1:0]     gnt,
    output logic              tout_pulse
);

    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic [1:0] {StIdle, StOwn, StAbort} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic [IW-1:0] winner, cand;
    logic          found;
    logic          own_psel;

    // First requester strictly after the previous owner, wrapping modulo NM.
    always_comb begin
        winner = last_q;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned off = 1; off <= NM; off++) begin
            cand = IW'((32'(last_q) + off) % NM);
            if (!found && m_psel[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign own_psel = m_psel[last_q];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            StIdle: begin
                wdog_d = '0;
                if (|m_psel) begin
                    state_d = StOwn;
                    last_d  = winner;
                end
            end
            StOwn: begin
                if (!own_psel) begin
                    state_d = StIdle;
                    wdog_d  = '0;
                end else if (pready) begin
                    wdog_d = '0;
                end else if (TIMEOUT != 0) begin
                    if (wdog_q == TW'(TIMEOUT - 1)) begin
                        state_d = StAbort;
                    end
                    if (wdog_q != TW'(TIMEOUT)) begin
                        wdog_d = wdog_q + TW'(1);
                    end
                end
            end
            StAbort: begin
                state_d = StIdle;
                wdog_d  = '0;
            end
            default: begin
                state_d = StIdle;
                wdog_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= IW'(NM - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    assign m_prdata = prdata;

    // The owner index is last_q for as long as the state is not idle.
    always_comb begin
        gnt        = '0;
        m_pready   = '0;
        m_presp    = '0;
        psel       = 1'b0;
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr      = '0;
        pwdata     = '0;
        pstrb      = '0;
        tout_pulse = 1'b0;
        if (state_q != StIdle) begin
            gnt[last_q] = 1'b1;
            pwrite      = m_pwrite[last_q];
            paddr       = m_paddr[{last_q, 5'b0} +: 32];
            pwdata      = m_pwdata[{last_q, 5'b0} +: 32];
            pstrb       = m_pstrb[{last_q, 2'b0} +: 4];
        end
        if (state_q == StOwn) begin
            psel                          = m_psel[last_q];
            penable                       = m_penable[last_q];
            m_pready[last_q]              = pready;
            m_presp[{last_q, 1'b0} +: 2]  = presp;
        end
        if (state_q == StAbort) begin
            m_pready[last_q]              = 1'b1;
            m_presp[{last_q, 1'b0} +: 2]  = 2'b10;
            tout_pulse                    = 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_share_arbiter.sv
// Directed bench for apb_share_arbiter: single transfer, contention, held
// ownership, round-robin order, watchdog abort and asynchronous reset.
module tb_apb_share_arbiter;

    localparam int NM = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM-1:0]     m_psel, m_penable, m_pwrite;
    logic [32*NM-1:0]  m_paddr, m_pwdata;
    logic [4*NM-1:0]   m_pstrb;
    logic [NM-1:0]     m_pready;
    logic [2*NM-1:0]   m_presp;
    logic [31:0]       m_prdata;
    logic              psel, penable, pwrite;
    logic [31:0]       paddr, pwdata;
    logic [3:0]        pstrb;
    logic              pready;
    logic [1:0]        presp;
    logic [31:0]       prdata;
    logic [NM-1:0]     gnt;
    logic              tout_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    apb_share_arbiter #(.NM(NM), .TIMEOUT(16), .TW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_psel     (m_psel),
        .m_penable  (m_penable),
        .m_pwrite   (m_pwrite),
        .m_paddr    (m_paddr),
        .m_pwdata   (m_pwdata),
        .m_pstrb    (m_pstrb),
        .m_pready   (m_pready),
        .m_presp    (m_presp),
        .m_prdata   (m_prdata),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pready     (pready),
        .presp      (presp),
        .prdata     (prdata),
        .gnt        (gnt),
        .tout_pulse (tout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic sel, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        m_psel[i]            = sel;
        m_penable[i]         = en;
        m_pwrite[i]          = wr;
        m_paddr[32*i +: 32]  = a;
        m_pwdata[32*i +: 32] = d;
        m_pstrb[4*i +: 4]    = 4'hF;
    endtask

    task automatic clear_inputs();
        m_psel    = '0;
        m_penable = '0;
        m_pwrite  = '0;
        m_paddr   = '0;
        m_pwdata  = '0;
        m_pstrb   = '0;
        pready    = 1'b0;
        presp     = 2'b00;
        prdata    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        // Reset state
        clear_inputs();
        #2;
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_psel", 64'(psel), 64'h0);
        check("rst_penable", 64'(penable), 64'h0);
        check("rst_paddr", 64'(paddr), 64'h0);
        check("rst_m_pready", 64'(m_pready), 64'h0);
        check("rst_tout", 64'(tout_pulse), 64'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;

        // Single master write, 3 wait states
        prdata = 32'h1234_5678;
        set_m(0, 1'b1, 1'b0, 1'b1, 32'h100, 32'hCAFE_0001);
        #1;
        check("t1_idle_psel", 64'(psel), 64'h0);
        check("t1_idle_gnt", 64'(gnt), 64'h0);
        check("t1_prdata", 64'(m_prdata), 64'h1234_5678);
        cyc();
        #1;
        check("t1_gnt", 64'(gnt), 64'h1);
        check("t1_psel", 64'(psel), 64'h1);
        check("t1_paddr", 64'(paddr), 64'h100);
        check("t1_pwdata", 64'(pwdata), 64'hCAFE_0001);
        check("t1_pwrite", 64'(pwrite), 64'h1);
        check("t1_setup_pready", 64'(m_pready), 64'h0);
        cyc();
        m_penable[0] = 1'b1;
        for (int w = 0; w < 3; w++) begin
            #1;
            check("t1_wait_pready", 64'(m_pready), 64'h0);
            check("t1_wait_penable", 64'(penable), 64'h1);
            cyc();
        end
        pready = 1'b1;
        #1;
        check("t1_done_pready", 64'(m_pready), 64'h1);
        check("t1_done_presp", 64'(m_presp), 64'h0);
        cyc();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        pready = 1'b0;
        #1;
        check("t1_rel_gnt", 64'(gnt), 64'h1);
        check("t1_rel_psel", 64'(psel), 64'h0);
        cyc();
        #1;
        check("t1_idle_after", 64'(gnt), 64'h0);

        // Contention after reset: m0 first, m1 two cycles after release
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hA);
        set_m(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'hB);
        cyc();
        #1;
        check("t2_gnt_m0", 64'(gnt), 64'h1);
        check("t2_paddr_m0", 64'(paddr), 64'h10);
        m_penable[0] = 1'b1;
        pready = 1'b1;
        #1;
        check("t2_pready_m0", 64'(m_pready), 64'h1);
        cyc();
        m_psel[0]    = 1'b0;
        m_penable[0] = 1'b0;
        pready       = 1'b0;
        #1;
        check("t2_gap0_psel", 64'(psel), 64'h0);
        check("t2_gap0_gnt", 64'(gnt), 64'h1);
        cyc();
        #1;
        check("t2_gap1_gnt", 64'(gnt), 64'h0);
        check("t2_gap1_psel", 64'(psel), 64'h0);
        cyc();
        #1;
        check("t2_gnt_m1", 64'(gnt), 64'h2);
        check("t2_psel_m1", 64'(psel), 64'h1);
        check("t2_paddr_m1", 64'(paddr), 64'h20);
        m_penable[1] = 1'b1;
        pready = 1'b1;
        #1;
        check("t2_pready_m1", 64'(m_pready), 64'h2);
        cyc();
        m_psel[1]    = 1'b0;
        m_penable[1] = 1'b0;
        pready       = 1'b0;
        cyc();
        cyc();

        // Held ownership across a split 64-bit access while m1 waits
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
        cyc();
        #1;
        check("t3_gnt_m0", 64'(gnt), 64'h1);
        check("t3_paddr_lo", 64'(paddr), 64'h200);
        m_penable[0] = 1'b1;
        pready = 1'b1;
        prdata = 32'hDEAD_0200;
        #1;
        check("t3_pready_lo", 64'(m_pready), 64'h1);
        check("t3_prdata", 64'(m_prdata), 64'hDEAD_0200);
        cyc();
        m_penable[0]  = 1'b0;
        m_paddr[31:0] = 32'h204;
        pready        = 1'b0;
        #1;
        check("t3_hold_gnt", 64'(gnt), 64'h1);
        check("t3_paddr_hi", 64'(paddr), 64'h204);
        cyc();
        m_penable[0] = 1'b1;
        pready = 1'b1;
        #1;
        check("t3_pready_hi", 64'(m_pready), 64'h1);
        cyc();
        m_psel[0]    = 1'b0;
        m_penable[0] = 1'b0;
        pready       = 1'b0;
        #1;
        check("t3_rel_gnt", 64'(gnt), 64'h1);
        cyc();
        #1;
        check("t3_idle_gnt", 64'(gnt), 64'h0);
        cyc();
        #1;
        check("t3_gnt_m1", 64'(gnt), 64'h2);
        check("t3_paddr_m1", 64'(paddr), 64'h300);
        m_psel[1] = 1'b0;
        cyc();
        cyc();

        // Round-robin with all four requesting
        do_reset();
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b0, 1'b0, 32'h400 + 32'(4 * i), 32'h0);
        for (int n = 0; n < 8; n++) begin
            logic [3:0] exp_gnt;
            exp_gnt = 4'b0001 << (n % NM);
            cyc();
            #1;
            check($sformatf("t4_gnt_%0d", n), 64'(gnt), 64'(exp_gnt));
            m_psel[n % NM] = 1'b0;
            cyc();
            #1;
            check($sformatf("t4_idle_%0d", n), 64'(gnt), 64'h0);
            m_psel[n % NM] = 1'b1;
        end
        m_psel = '0;
        cyc();

        // Watchdog abort: TIMEOUT=16, target never ready
        do_reset();
        set_m(2, 1'b1, 1'b0, 1'b1, 32'h500, 32'h55);
        cyc();
        #1;
        check("t5_gnt_m2", 64'(gnt), 64'h4);
        check("t5_psel", 64'(psel), 64'h1);
        m_penable[2] = 1'b1;
        for (int c = 2; c <= 16; c++) begin
            cyc();
            #1;
            check($sformatf("t5_tout_c%0d", c), 64'(tout_pulse), 64'h0);
            check($sformatf("t5_pready_c%0d", c), 64'(m_pready), 64'h0);
        end
        cyc();
        #1;
        check("t5_abort_tout", 64'(tout_pulse), 64'h1);
        check("t5_abort_pready", 64'(m_pready), 64'h4);
        check("t5_abort_presp", 64'(m_presp), 64'h20);
        check("t5_abort_psel", 64'(psel), 64'h0);
        check("t5_abort_penable", 64'(penable), 64'h0);
        check("t5_abort_gnt", 64'(gnt), 64'h4);
        m_psel[2]    = 1'b0;
        m_penable[2] = 1'b0;
        cyc();
        #1;
        check("t5_post_gnt", 64'(gnt), 64'h0);
        check("t5_post_tout", 64'(tout_pulse), 64'h0);
        check("t5_post_pready", 64'(m_pready), 64'h0);

        // pready on cycle 16 completes normally
        set_m(2, 1'b1, 1'b0, 1'b1, 32'h504, 32'h56);
        cyc();
        m_penable[2] = 1'b1;
        for (int c = 2; c <= 15; c++) cyc();
        cyc();
        pready = 1'b1;
        #1;
        check("t5b_pready", 64'(m_pready), 64'h4);
        check("t5b_presp", 64'(m_presp), 64'h0);
        check("t5b_tout16", 64'(tout_pulse), 64'h0);
        cyc();
        m_psel[2]    = 1'b0;
        m_penable[2] = 1'b0;
        pready       = 1'b0;
        #1;
        check("t5b_tout17", 64'(tout_pulse), 64'h0);
        check("t5b_pready17", 64'(m_pready), 64'h0);
        check("t5b_gnt17", 64'(gnt), 64'h4);
        cyc();
        #1;
        check("t5b_idle_gnt", 64'(gnt), 64'h0);

        // Asynchronous reset mid-transfer
        set_m(1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h66);
        cyc();
        m_penable[1] = 1'b1;
        pready = 1'b1;
        #1;
        check("t6_gnt_m1", 64'(gnt), 64'h2);
        check("t6_pready_m1", 64'(m_pready), 64'h2);
        check("t6_psel_pre", 64'(psel), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_psel", 64'(psel), 64'h0);
        check("t6_rst_penable", 64'(penable), 64'h0);
        check("t6_rst_gnt", 64'(gnt), 64'h0);
        check("t6_rst_pready", 64'(m_pready), 64'h0);
        #1;
        rst_n  = 1'b1;
        pready = 1'b0;
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b0, 1'b0, 32'h700 + 32'(4 * i), 32'h0);
        cyc();
        #1;
        check("t6_first_gnt", 64'(gnt), 64'h1);
        check("t6_first_paddr", 64'(paddr), 64'h700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
